// File: rtl/contador_nbits_mod.sv
// Parametrised modulo-MOD up/down counter with parallel load, wrap or saturate
// behaviour, combinational terminal count and registered wrap/load-error pulses.
module contador_nbits_mod #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MOD      = 16,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             count,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] salida,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    // The modulus may equal 2**WIDTH, so range checks use the top value rather than the modulus.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 64'd1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             at_max, at_min, step;

    assign at_max = (cnt_q == MAX_VAL);
    assign at_min = (cnt_q == '0);
    assign step   = enable & count & ~load;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (enable && load) begin
            if (load_val <= MAX_VAL) begin
                cnt_d = load_val;
            end else begin
                cnt_d = MAX_VAL;
                err_d = 1'b1;
            end
        end else if (step) begin
            if (up_down) begin
                if (!at_max) begin
                    cnt_d = cnt_q + WIDTH'(1);
                end else if (!SATURATE) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (!at_min) begin
                    cnt_d = cnt_q - WIDTH'(1);
                end else if (!SATURATE) begin
                    cnt_d  = MAX_VAL;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    // Terminal count looks at the current state, so a chained stage steps on the same edge.
    assign tc       = step & (up_down ? at_max : at_min);
    assign salida   = cnt_q;
    assign wrap     = wrap_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_contador_nbits_mod.sv
// Scoreboard bench: three counter configurations share one stimulus stream and
// are compared every cycle against an arithmetic reference model.
module tb_contador_nbits_mod;

    logic       clk = 1'b0;
    logic       rst, enable, count, up_down, load;
    logic [3:0] load_val;

    logic [3:0] sal_a, sal_b, sal_c;
    logic       tc_a, tc_b, tc_c, wr_a, wr_b, wr_c, le_a, le_b, le_c;

    // a: MOD=16 wrap, b: MOD=10 wrap, c: MOD=10 saturate
    contador_nbits_mod #(.WIDTH(4), .MOD(16), .SATURATE(1'b0)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .count(count), .up_down(up_down),
        .load(load), .load_val(load_val), .salida(sal_a), .tc(tc_a), .wrap(wr_a),
        .load_err(le_a));
    contador_nbits_mod #(.WIDTH(4), .MOD(10), .SATURATE(1'b0)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .count(count), .up_down(up_down),
        .load(load), .load_val(load_val), .salida(sal_b), .tc(tc_b), .wrap(wr_b),
        .load_err(le_b));
    contador_nbits_mod #(.WIDTH(4), .MOD(10), .SATURATE(1'b1)) dut_c (
        .clk(clk), .rst(rst), .enable(enable), .count(count), .up_down(up_down),
        .load(load), .load_val(load_val), .salida(sal_c), .tc(tc_c), .wrap(wr_c),
        .load_err(le_c));

    always #5 clk = ~clk;

    // Per instance 7 bits: {tc (pre-edge), wrap, load_err, salida (post-edge)}
    logic [20:0] exp_q[$];
    int          total_checks  = 0;
    int          passed_checks = 0;
    int          st_a, st_b, st_c;

    task automatic model(input int s, input int md, input bit sat,
                         input bit r, input bit en, input bit cn, input bit ud,
                         input bit ld, input int lv,
                         output int ns, output bit w, output bit e, output bit t);
        t  = en && cn && !ld && (ud ? (s == md - 1) : (s == 0));
        ns = s;
        w  = 1'b0;
        e  = 1'b0;
        if (r) begin
            ns = 0;
        end else if (en && ld) begin
            if (lv < md) begin
                ns = lv;
            end else begin
                ns = md - 1;
                e  = 1'b1;
            end
        end else if (en && cn) begin
            if (ud) begin
                if (s == md - 1) begin
                    if (!sat) begin ns = 0; w = 1'b1; end
                end else ns = s + 1;
            end else begin
                if (s == 0) begin
                    if (!sat) begin ns = md - 1; w = 1'b1; end
                end else ns = s - 1;
            end
        end
    endtask

    task automatic drive(input bit r, input bit en, input bit cn, input bit ud,
                         input bit ld, input int lv);
        int  na, nb, nc;
        bit  wa, wb, wc, ea, eb, ec, ta, tb, tcc;
        @(negedge clk);
        rst      = r;
        enable   = en;
        count    = cn;
        up_down  = ud;
        load     = ld;
        load_val = 4'(lv);
        model(st_a, 16, 1'b0, r, en, cn, ud, ld, lv, na, wa, ea, ta);
        model(st_b, 10, 1'b0, r, en, cn, ud, ld, lv, nb, wb, eb, tb);
        model(st_c, 10, 1'b1, r, en, cn, ud, ld, lv, nc, wc, ec, tcc);
        st_a = na;
        st_b = nb;
        st_c = nc;
        exp_q.push_back({ta, wa, ea, 4'(na), tb, wb, eb, 4'(nb), tcc, wc, ec, 4'(nc)});
    endtask

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("FAIL %s: got tc=%b wrap=%b load_err=%b salida=%0d, want tc=%b wrap=%b load_err=%b salida=%0d",
                      name, act[6], act[5], act[4], act[3:0], exp[6], exp[5], exp[4], exp[3:0]);
    endtask

    // Monitor: tc sampled before the edge, registered outputs just after it.
    initial begin
        logic        ta_s, tb_s, tc_s;
        logic [20:0] e;
        forever begin
            @(negedge clk);
            #4;
            ta_s = tc_a;
            tb_s = tc_b;
            tc_s = tc_c;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mod16_wrap", {ta_s, wr_a, le_a, sal_a}, e[20:14]);
                check("mod10_wrap", {tb_s, wr_b, le_b, sal_b}, e[13:7]);
                check("mod10_sat",  {tc_s, wr_c, le_c, sal_c}, e[6:0]);
            end
        end
    end

    initial begin
        bit ud;
        rst = 1'b0; enable = 1'b0; count = 1'b0; up_down = 1'b0; load = 1'b0; load_val = '0;
        st_a = 0; st_b = 0; st_c = 0;

        // Reset, then count up through a full wrap of every instance.
        drive(1, 0, 0, 0, 0, 0);
        repeat (20) drive(0, 1, 1, 1, 0, 0);

        // Count down from 0: wrap to MOD-1 or hold at 0 when saturating.
        drive(1, 0, 0, 0, 0, 0);
        repeat (12) drive(0, 1, 1, 0, 0, 0);

        // Load wins over count; out-of-range load clamps and flags.
        drive(0, 1, 1, 1, 1, 7);
        drive(0, 1, 0, 1, 0, 0);
        drive(0, 1, 1, 1, 1, 12);
        drive(0, 1, 0, 1, 0, 0);

        // Disabled: nothing moves even with count and load requested.
        repeat (5) drive(0, 0, 1, 1, 1, 3);

        // Reset beats a load, and beats a wrapping step at MOD-1.
        drive(1, 1, 1, 1, 1, 5);
        drive(0, 1, 0, 1, 1, 9);
        drive(1, 1, 1, 1, 0, 0);
        drive(0, 1, 0, 1, 1, 15);
        drive(1, 1, 1, 1, 0, 0);

        // Alternate direction every edge starting from 3.
        drive(0, 1, 0, 1, 1, 3);
        ud = 1'b1;
        repeat (10) begin
            drive(0, 1, 1, ud, 0, 0);
            ud = ~ud;
        end

        // Randomised run.
        repeat (10000) begin
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)));
        end

        drive(0, 0, 0, 0, 0, 0);
        begin : drain
            int waited = 0;
            while (exp_q.size() > 0 && waited < 20) begin
                @(posedge clk);
                waited++;
            end
        end
        repeat (2) @(posedge clk);
        total_checks++;
        if (exp_q.size() == 0) passed_checks++;
        else $display("FAIL queue_drain: %0d entries left, want 0", exp_q.size());

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
